// File: rtl/idex_stage.sv
// rtl/idex_stage.sv - ID/EX pipeline register with load-use hazard detection and bubble counter
//
// Purpose:
//   Holds decoded instruction state between ID and EX. A load in ID/EX whose
//   destination matches a source of the instruction in IF/ID is a load-use
//   hazard. On a hazard, stall is raised and a bubble is written in place of
//   the dependent instruction. A branch/jump flush squashes the register.
//   Update priority on each edge: flush > stall > load.
//
// Ports:
//   clk, rst                  clock, asynchronous active-high reset
//   inst_ifid[15:0]           IF/ID instruction: [11:8] rd, [7:4] rs, [3:0] rt
//   rd1_id, rd2_id, imm_id    register read data and sign-extended immediate
//   rf_wen_id, mem2reg_id,
//   mem_ren_id, mem_wen_id    decoded controls
//   alu_op_id[3:0]            decoded ALU operation
//   flush                     squash ID/EX contents
//   *_idex                    registered ID/EX contents
//   inst_curr_IDEX_7_4_rs/_3_0_rt  registered source register numbers
//   stall                     combinational load-use hold request
//   stall_count[15:0]         saturating count of inserted load-use bubbles

module idex_stage #(
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [15:0]       inst_ifid,
    input  logic [DATA_W-1:0] rd1_id,
    input  logic [DATA_W-1:0] rd2_id,
    input  logic [DATA_W-1:0] imm_id,
    input  logic              rf_wen_id,
    input  logic              mem2reg_id,
    input  logic              mem_ren_id,
    input  logic              mem_wen_id,
    input  logic [3:0]        alu_op_id,
    input  logic              flush,
    output logic [3:0]        inst_curr_IDEX_7_4_rs,
    output logic [3:0]        inst_curr_IDEX_3_0_rt,
    output logic [3:0]        rf_waddr_idex,
    output logic              rf_wen_idex,
    output logic              mem2reg_idex,
    output logic              mem_ren_idex,
    output logic              mem_wen_idex,
    output logic              valid_idex,
    output logic [3:0]        alu_op_idex,
    output logic [DATA_W-1:0] rd1_idex,
    output logic [DATA_W-1:0] rd2_idex,
    output logic [DATA_W-1:0] imm_idex,
    output logic              stall,
    output logic [15:0]       stall_count
);

    logic [3:0]        r_rs;
    logic [3:0]        r_rt;
    logic [3:0]        r_waddr;
    logic              r_rf_wen;
    logic              r_mem2reg;
    logic              r_mem_ren;
    logic              r_mem_wen;
    logic              r_valid;
    logic [3:0]        r_alu_op;
    logic [DATA_W-1:0] r_rd1;
    logic [DATA_W-1:0] r_rd2;
    logic [DATA_W-1:0] r_imm;
    logic [15:0]       r_stall_count;

    logic w_src_match;
    logic w_stall;
    logic w_bubble;

    // Only a valid load with a non-zero destination can produce a hazard;
    // r0 is hardwired and never a real dependency. flush is deliberately
    // absent here so stall has no combinational path from it.
    assign w_src_match = (r_waddr == inst_ifid[7:4]) || (r_waddr == inst_ifid[3:0]);
    assign w_stall     = r_valid && r_mem_ren && (r_waddr != 4'd0) && w_src_match;
    assign w_bubble    = flush || w_stall;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rs      <= '0;
            r_rt      <= '0;
            r_waddr   <= '0;
            r_rf_wen  <= 1'b0;
            r_mem2reg <= 1'b0;
            r_mem_ren <= 1'b0;
            r_mem_wen <= 1'b0;
            r_valid   <= 1'b0;
            r_alu_op  <= '0;
            r_rd1     <= '0;
            r_rd2     <= '0;
            r_imm     <= '0;
        end else if (w_bubble) begin
            // Flush and load-use bubble zero the register identically.
            r_rs      <= '0;
            r_rt      <= '0;
            r_waddr   <= '0;
            r_rf_wen  <= 1'b0;
            r_mem2reg <= 1'b0;
            r_mem_ren <= 1'b0;
            r_mem_wen <= 1'b0;
            r_valid   <= 1'b0;
            r_alu_op  <= '0;
            r_rd1     <= '0;
            r_rd2     <= '0;
            r_imm     <= '0;
        end else begin
            r_rs      <= inst_ifid[7:4];
            r_rt      <= inst_ifid[3:0];
            r_waddr   <= inst_ifid[11:8];
            r_rf_wen  <= rf_wen_id;
            r_mem2reg <= mem2reg_id;
            r_mem_ren <= mem_ren_id;
            r_mem_wen <= mem_wen_id;
            r_valid   <= 1'b1;
            r_alu_op  <= alu_op_id;
            r_rd1     <= rd1_id;
            r_rd2     <= rd2_id;
            r_imm     <= imm_id;
        end
    end

    // A bubble is counted only when the stall actually wins the edge; a
    // coincident flush takes priority and the squash is not a load-use bubble.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stall_count <= '0;
        end else if (w_stall && !flush && (r_stall_count != 16'hFFFF)) begin
            r_stall_count <= r_stall_count + 16'd1;
        end
    end

    assign inst_curr_IDEX_7_4_rs = r_rs;
    assign inst_curr_IDEX_3_0_rt = r_rt;
    assign rf_waddr_idex         = r_waddr;
    assign rf_wen_idex           = r_rf_wen;
    assign mem2reg_idex          = r_mem2reg;
    assign mem_ren_idex          = r_mem_ren;
    assign mem_wen_idex          = r_mem_wen;
    assign valid_idex            = r_valid;
    assign alu_op_idex           = r_alu_op;
    assign rd1_idex              = r_rd1;
    assign rd2_idex              = r_rd2;
    assign imm_idex              = r_imm;
    assign stall                 = w_stall;
    assign stall_count           = r_stall_count;

endmodule

// File: tb/tb_idex_stage.sv
// tb/tb_idex_stage.sv - self-checking bench for idex_stage with expected-value scoreboard

module tb_idex_stage;

    logic        clk;
    logic        rst;
    logic [15:0] inst_ifid;
    logic [15:0] rd1_id, rd2_id, imm_id;
    logic        rf_wen_id, mem2reg_id, mem_ren_id, mem_wen_id;
    logic [3:0]  alu_op_id;
    logic        flush;
    logic [3:0]  inst_curr_IDEX_7_4_rs, inst_curr_IDEX_3_0_rt, rf_waddr_idex;
    logic        rf_wen_idex, mem2reg_idex, mem_ren_idex, mem_wen_idex, valid_idex;
    logic [3:0]  alu_op_idex;
    logic [15:0] rd1_idex, rd2_idex, imm_idex;
    logic        stall;
    logic [15:0] stall_count;

    int n_pass  = 0;
    int n_total = 0;

    // Expected ID/EX image:
    // {valid, rf_wen, mem2reg, mem_ren, mem_wen, alu_op, waddr, rs, rt, rd1, rd2, imm}
    logic [68:0] sb[$];

    // Reference state of the register, updated from the expected images.
    logic        m_valid;
    logic        m_mren;
    logic [3:0]  m_waddr;
    logic [15:0] m_count;

    idex_stage #(.DATA_W(16)) dut (
        .clk                   (clk),
        .rst                   (rst),
        .inst_ifid             (inst_ifid),
        .rd1_id                (rd1_id),
        .rd2_id                (rd2_id),
        .imm_id                (imm_id),
        .rf_wen_id             (rf_wen_id),
        .mem2reg_id            (mem2reg_id),
        .mem_ren_id            (mem_ren_id),
        .mem_wen_id            (mem_wen_id),
        .alu_op_id             (alu_op_id),
        .flush                 (flush),
        .inst_curr_IDEX_7_4_rs (inst_curr_IDEX_7_4_rs),
        .inst_curr_IDEX_3_0_rt (inst_curr_IDEX_3_0_rt),
        .rf_waddr_idex         (rf_waddr_idex),
        .rf_wen_idex           (rf_wen_idex),
        .mem2reg_idex          (mem2reg_idex),
        .mem_ren_idex          (mem_ren_idex),
        .mem_wen_idex          (mem_wen_idex),
        .valid_idex            (valid_idex),
        .alu_op_idex           (alu_op_idex),
        .rd1_idex              (rd1_idex),
        .rd2_idex              (rd2_idex),
        .imm_idex              (imm_idex),
        .stall                 (stall),
        .stall_count           (stall_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [68:0] observed();
        return {valid_idex, rf_wen_idex, mem2reg_idex, mem_ren_idex, mem_wen_idex,
                alu_op_idex, rf_waddr_idex, inst_curr_IDEX_7_4_rs, inst_curr_IDEX_3_0_rt,
                rd1_idex, rd2_idex, imm_idex};
    endfunction

    task automatic chk(input string tag, input logic [68:0] obs, input logic [68:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic model_reset();
        m_valid = 1'b0;
        m_mren  = 1'b0;
        m_waddr = 4'd0;
        m_count = 16'd0;
    endtask

    // One cycle: drive ID inputs, check stall, predict the next ID/EX image,
    // clock, then compare the popped prediction and the bubble counter.
    task automatic step(input string tag, input logic [15:0] inst, input logic wen,
                        input logic mren, input logic mwen, input logic [3:0] alu,
                        input logic fl);
        logic        exp_stall;
        logic [68:0] exp;
        logic [68:0] e;
        inst_ifid  = inst;
        rd1_id     = 16'($urandom);
        rd2_id     = 16'($urandom);
        imm_id     = 16'($urandom);
        rf_wen_id  = wen;
        mem2reg_id = mren;
        mem_ren_id = mren;
        mem_wen_id = mwen;
        alu_op_id  = alu;
        flush      = fl;
        #1;
        exp_stall = m_valid && m_mren && (m_waddr != 4'd0) &&
                    ((m_waddr == inst[7:4]) || (m_waddr == inst[3:0]));
        chk({tag, "_stall"}, 69'(stall), 69'(exp_stall));
        if (fl || exp_stall)
            exp = '0;
        else
            exp = {1'b1, wen, mren, mren, mwen, alu, inst[11:8], inst[7:4], inst[3:0],
                   rd1_id, rd2_id, imm_id};
        sb.push_back(exp);
        if (exp_stall && !fl && (m_count != 16'hFFFF))
            m_count = m_count + 16'd1;
        @(posedge clk);
        #1;
        e       = sb.pop_front();
        m_valid = e[68];
        m_mren  = e[65];
        m_waddr = e[59:56];
        chk({tag, "_idex"}, observed(), e);
        chk({tag, "_count"}, 69'(stall_count), 69'(m_count));
    endtask

    initial begin
        rst        = 1'b1;
        inst_ifid  = '0;
        rd1_id     = '0;
        rd2_id     = '0;
        imm_id     = '0;
        rf_wen_id  = 1'b0;
        mem2reg_id = 1'b0;
        mem_ren_id = 1'b0;
        mem_wen_id = 1'b0;
        alu_op_id  = '0;
        flush      = 1'b0;
        model_reset();
        #12;
        chk("reset_idex", observed(), 69'd0);
        chk("reset_stall", 69'(stall), 69'd0);
        chk("reset_count", 69'(stall_count), 69'd0);
        @(negedge clk);
        rst = 1'b0;

        // Load r5, then a user of r5: one stall, one bubble, then the reload.
        step("ld_r5",    16'h0512, 1'b1, 1'b1, 1'b0, 4'h0, 1'b0);
        step("use_r5_a", 16'h0854, 1'b1, 1'b0, 1'b0, 4'h2, 1'b0);
        step("use_r5_b", 16'h0854, 1'b1, 1'b0, 1'b0, 4'h2, 1'b0);

        // Back-to-back dependent loads each get one bubble.
        step("ld_r6",    16'h0611, 1'b1, 1'b1, 1'b0, 4'h0, 1'b0);
        step("ld_r7_a",  16'h0736, 1'b1, 1'b1, 1'b0, 4'h0, 1'b0);
        step("ld_r7_b",  16'h0736, 1'b1, 1'b1, 1'b0, 4'h0, 1'b0);
        step("use_r7_a", 16'h0a17, 1'b1, 1'b0, 1'b0, 4'h1, 1'b0);
        step("use_r7_b", 16'h0a17, 1'b1, 1'b0, 1'b0, 4'h1, 1'b0);

        // Load to r0 never stalls.
        step("ld_r0",    16'h0023, 1'b0, 1'b1, 1'b0, 4'h0, 1'b0);
        step("use_r0",   16'h0400, 1'b1, 1'b0, 1'b0, 4'h3, 1'b0);

        // ALU result in r3 does not stall its user.
        step("alu_r3",   16'h0312, 1'b1, 1'b0, 1'b0, 4'h5, 1'b0);
        step("use_r3",   16'h0b34, 1'b1, 1'b0, 1'b1, 4'h6, 1'b0);

        // Flush wins over a simultaneous load-use stall and is not counted.
        step("ld_r7",    16'h0745, 1'b1, 1'b1, 1'b0, 4'h0, 1'b0);
        step("flush_ld", 16'h0c72, 1'b1, 1'b0, 1'b0, 4'h7, 1'b1);
        step("post_fl",  16'h0c72, 1'b1, 1'b0, 1'b0, 4'h7, 1'b0);

        // Counter saturation: preset near the top, then three load-use stalls.
        force dut.r_stall_count = 16'hFFFE;
        #1;
        release dut.r_stall_count;
        m_count = 16'hFFFE;
        step("sat_ld",   16'h0912, 1'b1, 1'b1, 1'b0, 4'h0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step("sat_use_a", 16'h0991, 1'b1, 1'b1, 1'b0, 4'h0, 1'b0);
            step("sat_use_b", 16'h0991, 1'b1, 1'b1, 1'b0, 4'h0, 1'b0);
        end

        // Asynchronous reset between edges while a stall is pending.
        inst_ifid  = 16'h0d93;
        mem_ren_id = 1'b0;
        flush      = 1'b0;
        #1;
        chk("pre_rst_stall", 69'(stall), 69'd1);
        rst = 1'b1;
        #1;
        model_reset();
        chk("async_rst_idex", observed(), 69'd0);
        chk("async_rst_stall", 69'(stall), 69'd0);
        chk("async_rst_count", 69'(stall_count), 69'd0);
        @(negedge clk);
        rst = 1'b0;

        // First edge after reset is a normal load.
        step("post_rst", 16'h0d93, 1'b1, 1'b0, 1'b0, 4'h4, 1'b0);
        step("post_rst2", 16'h0e12, 1'b1, 1'b1, 1'b0, 4'h0, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
